// File: rtl/rv_fetch_queue_if.sv
// Interface for the fetch front end. It carries the instruction-memory request and
// response channels, the branch redirect, the decode-side handshake and the halt flag.
interface rv_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            ins_valid;
  logic            ins_ready;
  logic [31:0]     ins_data;
  logic [XLEN-1:0] ins_pc;
  logic            exit;

  modport master (
    output imem_req_valid, imem_req_addr, ins_valid, ins_data, ins_pc, exit,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           ins_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, ins_valid, ins_data, ins_pc, exit,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           ins_ready
  );
endinterface

// File: rtl/rv_fetch_queue.sv
// RV32 fetch front end: PC generator, single-outstanding imem requester and a
// DEPTH-entry prefetch FIFO with redirect flush and all-zero halt-word detection.
module rv_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst_n,
  rv_fetch_queue_if.master bus
);
  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HALT} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_issue_pc;
  logic [31:0]     r_mem_data [DEPTH];
  logic [XLEN-1:0] r_mem_pc   [DEPTH];
  logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [AW:0]     r_count;
  logic            r_drop;
  logic            r_exit;

  logic w_empty, w_not_full, w_head_zero;
  logic w_req_fire, w_rsp_take, w_push, w_pop;

  assign w_empty     = (r_count == '0);
  assign w_not_full  = (r_count < FULL);
  assign w_head_zero = !w_empty && (r_mem_data[r_rd_ptr] == 32'h0);
  assign w_req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  // A response is only meaningful while a request is outstanding.
  assign w_rsp_take  = (r_state == S_WAIT) && bus.imem_rsp_valid;
  assign w_push      = w_rsp_take && !r_drop && !bus.redirect_valid;
  assign w_pop       = bus.ins_valid && bus.ins_ready && !bus.redirect_valid;

  // NOTE: sequential blocks use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FETCH: if (w_req_fire) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (w_push && bus.imem_rsp_data == 32'h0) w_state_nxt = S_HALT;
          else                                      w_state_nxt = S_FETCH;
        end
      end
      S_HALT:  if (bus.redirect_valid && !r_exit) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Outputs are forced inactive while reset is asserted, independent of stored state.
  always_comb begin
    bus.imem_req_valid = rst_n && (r_state == S_FETCH) && w_not_full &&
                         !bus.redirect_valid && !r_exit;
    bus.imem_req_addr  = r_fetch_pc;
    bus.ins_valid      = rst_n && !w_empty && !w_head_zero && !r_exit;
    bus.ins_data       = r_mem_data[r_rd_ptr];
    bus.ins_pc         = r_mem_pc[r_rd_ptr];
    bus.exit           = rst_n && r_exit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_issue_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_drop     <= 1'b0;
      r_exit     <= 1'b0;
    end else begin
      if (w_head_zero) r_exit <= 1'b1;
      if (bus.redirect_valid) begin
        r_fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        // Still outstanding only if the response did not land on this same edge.
        r_drop     <= (r_state == S_WAIT) && !bus.imem_rsp_valid;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
          r_issue_pc <= r_fetch_pc;
        end
        if (w_rsp_take && r_drop) r_drop   <= 1'b0;
        if (w_push)               r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)                r_rd_ptr <= r_rd_ptr + 1'b1;
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // NOTE: storage is not reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= bus.imem_rsp_data;
      r_mem_pc[r_wr_ptr]   <= r_issue_pc;
    end
  end
endmodule

// File: doc/rv_fetch_queue.md
Name: rv_fetch_queue

Overview:
Parametrised instruction-fetch front end for the RV32 core. It replaces the single-cycle fetch path, which indexes a byte array directly and has no reset, with a PC generator, a valid/ready instruction-memory request/response interface, and a DEPTH-entry prefetch FIFO. The FIFO supports branch redirect and flush, and detects the all-zero halt word. It sits between instruction memory and the decode stage and drives the core's exit signal.

Parameters:
XLEN, 32, PC and address width; instruction width is fixed at 32.
DEPTH, 4, prefetch FIFO entries; power of two, 2..16.
RESET_PC, 0, PC loaded on reset; bits [1:0] must be 0.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts the request.
imem_req_addr  out  XLEN  word-aligned fetch address.
imem_rsp_valid  in  1  response data valid; responses arrive in order, at least 1 cycle after acceptance.
imem_rsp_data  in  32  fetched instruction word.
redirect_valid  in  1  branch/jump taken; flush the queue and refetch.
redirect_pc  in  XLEN  target PC; bits [1:0] are forced to 0.
ins_valid  out  1  head of queue valid toward decode.
ins_ready  in  1  decode consumes the head.
ins_data  out  32  head instruction.
ins_pc  out  XLEN  PC of the head instruction.
exit  out  1  sticky halt flag; the zero word has reached the head.

Behaviour:
- Reset (rst_n=0 at an edge):
  - fetch_pc=RESET_PC; FIFO emptied; outstanding=0; drop=0; fetch_halt=0; exit=0.
  - Outputs during reset: imem_req_valid=0, ins_valid=0, exit=0.
  - Reset mid-transaction discards any outstanding response; it is not enqueued.
- Fetch FSM states:
  - FETCH: may issue a request.
  - WAIT: one request outstanding.
  - HALT: fetch stopped.
  - At most one request is outstanding at a time.
- Request issue:
  - imem_req_valid = (state==FETCH) & (count < DEPTH) & !redirect_valid & !exit.
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (wraps mod 2^XLEN) and state -> WAIT.
  - imem_req_valid, once asserted, holds with a stable address until ready, unless a redirect occurs.
- Response handling:
  - In WAIT, imem_rsp_valid & !drop -> the word is written into the FIFO together with its PC (fetch_pc-4 captured at issue).
  - If the word is 0x00000000: state -> HALT, otherwise state -> FETCH.
  - If drop=1, the response is discarded, drop clears, and state -> FETCH.
  - The FIFO write is visible on ins_valid the next cycle (registered FIFO, 1-cycle enqueue-to-head latency minimum).
- Dequeue:
  - ins_valid & ins_ready pops the head.
  - Simultaneous push and pop is allowed at any occupancy; count is unchanged.
  - Issue is gated on count<DEPTH and only one request is in flight, so a push never overflows.
- Redirect (redirect_valid=1 at an edge), highest priority:
  - FIFO flushed (count=0) and fetch_pc = {redirect_pc[XLEN-1:2],2'b00}.
  - Any ins_ready pop that cycle is ignored.
  - A response arriving the same cycle is discarded.
  - If a request is still outstanding after the edge, drop=1; state is WAIT if outstanding, else FETCH.
  - HALT -> FETCH, unless exit=1.
- Halt:
  - When the head entry holds 0x00000000: ins_valid=0 for it and exit=1 from the next cycle on.
  - exit is sticky until reset; redirect does not clear it.
  - Entries behind the zero word are never presented.
- Output stability: ins_data and ins_pc hold their values while ins_valid=1 and ins_ready=0.

Test Plan:
- Reset, then 0-wait memory returning words 0x00500093, 0x00100113, 0x00000000, with ins_ready=1 -> ins_pc sequence 0,4 with matching data; exactly 3 requests issued (addr 0,4,8); exit=1 one cycle after word 8 reaches the head; no further requests.
- DEPTH=4, ins_ready=0, 1-cycle memory latency -> 4 entries fetched (PCs 0..12), then imem_req_valid stays 0; raise ins_ready -> PCs 0,4,8,12 delivered in order; fetching resumes at 16.
- Request outstanding at addr 8, redirect_valid with redirect_pc=0x23 the next cycle, then a response of 0xDEADBEEF -> response dropped; next request addr 0x20; first delivered ins_pc=0x20.
- redirect_valid asserted in the same cycle as imem_rsp_valid and ins_valid&ins_ready -> FIFO empty next cycle, no pop of stale data, no enqueue; fetch restarts at the target.
- Zero word enqueued behind 2 valid entries, then a redirect to 0x40 before the zero word reaches the head -> exit stays 0; fetching resumes at 0x40.
- rst_n=0 for one cycle while in WAIT with 2 entries queued -> next cycle: ins_valid=0, exit=0, first request addr=RESET_PC; the late response is not enqueued.
